// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: FU result handshake plus CDB broadcast bundle shared by the FUs and the arbiter.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif
`ifndef XLEN
`define XLEN 32
`endif
interface cdb_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int TAG_W = `ROB_TAG_LEN,
    parameter int XLEN  = `XLEN,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic                  flush;
    logic [N_REQ-1:0]      fu_valid;
    logic [N_REQ*TAG_W-1:0] fu_tag;
    logic [N_REQ*XLEN-1:0] fu_data;
    logic [N_REQ*XLEN-1:0] fu_target_pc;
    logic [N_REQ-1:0]      fu_mispredict;
    logic [N_REQ-1:0]      fu_ready;
    logic                  cdb_valid;
    logic [TAG_W-1:0]      cdb_tag;
    logic [XLEN-1:0]       cdb_data;
    logic [XLEN-1:0]       cdb_target_pc;
    logic                  cdb_mispredict;
    logic [ID_W-1:0]       cdb_grant_id;
    modport master (
        output flush, fu_valid, fu_tag, fu_data, fu_target_pc, fu_mispredict,
        input  fu_ready, cdb_valid, cdb_tag, cdb_data, cdb_target_pc, cdb_mispredict, cdb_grant_id
    );
    modport slave (
        input  flush, fu_valid, fu_tag, fu_data, fu_target_pc, fu_mispredict,
        output fu_ready, cdb_valid, cdb_tag, cdb_data, cdb_target_pc, cdb_mispredict, cdb_grant_id
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: one-entry slot per FU, one CDB grant per cycle (round-robin, or lowest index
// when CDB_ARB_FIXED_PRIO_EN is defined).
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif
`ifndef XLEN
`define XLEN 32
`endif
module cdb_arbiter #(
    parameter int N_REQ = 4,
    parameter int TAG_W = `ROB_TAG_LEN,
    parameter int XLEN  = `XLEN
) (
    input logic          clk,
    input logic          reset,
    cdb_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(N_REQ);
    logic [N_REQ-1:0] slot_valid;
    logic [N_REQ-1:0] slot_mis;
    logic [TAG_W-1:0] slot_tag [N_REQ];
    logic [XLEN-1:0]  slot_data [N_REQ];
    logic [XLEN-1:0]  slot_pc [N_REQ];
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  base;
    logic [ID_W-1:0]  gid;
    logic             any;
`ifdef CDB_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [ID_W-1:0] rr_ptr;
    assign base = rr_ptr;
    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= '0;
        else if (any)
            rr_ptr <= (gid == ID_W'(N_REQ - 1)) ? '0 : gid + 1'b1;
    end
`endif
    // Scan from the far end back toward base so the last hit is the first valid slot in order.
    always_comb begin
        any = |slot_valid;
        gid = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(base) + k;
            idx = (idx >= N_REQ) ? idx - N_REQ : idx;
            if (slot_valid[idx])
                gid = ID_W'(idx);
        end
        grant = '0;
        grant[gid] = any;
    end
    assign bus.fu_ready       = ~slot_valid | grant;
    assign bus.cdb_valid      = any;
    assign bus.cdb_grant_id   = any ? gid : '0;
    assign bus.cdb_tag        = any ? slot_tag[gid] : '0;
    assign bus.cdb_data       = any ? slot_data[gid] : '0;
    assign bus.cdb_target_pc  = any ? slot_pc[gid] : '0;
    assign bus.cdb_mispredict = any & slot_mis[gid];
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (reset) begin
                slot_valid[i] <= 1'b0;
                slot_mis[i]   <= 1'b0;
                slot_tag[i]   <= '0;
                slot_data[i]  <= '0;
                slot_pc[i]    <= '0;
            end else if (bus.flush) begin
                slot_valid[i] <= 1'b0;
            end else if (bus.fu_valid[i] && (!slot_valid[i] || grant[i])) begin
                slot_valid[i] <= 1'b1;
                slot_mis[i]   <= bus.fu_mispredict[i];
                slot_tag[i]   <= bus.fu_tag[i*TAG_W +: TAG_W];
                slot_data[i]  <= bus.fu_data[i*XLEN +: XLEN];
                slot_pc[i]    <= bus.fu_target_pc[i*XLEN +: XLEN];
            end else if (grant[i]) begin
                slot_valid[i] <= 1'b0;
            end
        end
    end
endmodule
